// File: rtl/simd_issue.sv
// Issue / operand-fetch stage for the 256-bit SIMD executor: decodes instruction words,
// reads two vector operands, tracks busy registers and writes results back after WB_DELAY cycles.

module simd_issue_vreg (
  input  logic         clk,
  input  logic         rst,
  input  logic         wb_en,
  input  logic         ld_en,
  input  logic         set_busy,
  input  logic [255:0] wb_data,
  input  logic [255:0] ld_data,
  output logic [255:0] q,
  output logic         busy
);
  // Writeback and load never hit the same register in one cycle; wb wins for safety.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (wb_en)      q <= wb_data;
      else if (ld_en) q <= ld_data;
      if (set_busy)   busy <= 1'b1;
      else if (wb_en) busy <= 1'b0;
    end
  end
endmodule

module simd_issue #(
  parameter int WB_DELAY = 3,
  parameter int NREGS    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  input  logic [31:0]  instr,
  output logic         instr_ready,
  output logic [3:0]   exec_opcode,
  output logic [2:0]   exec_data_mode,
  output logic         exec_imm_flag,
  output logic [7:0]   exec_imm,
  output logic [255:0] exec_A,
  output logic [255:0] exec_B,
  input  logic [255:0] exec_res,
  input  logic         ld_valid,
  input  logic [2:0]   ld_addr,
  input  logic [255:0] ld_data,
  output logic         ld_ready,
  input  logic [2:0]   dbg_addr,
  output logic [255:0] dbg_data,
  output logic [7:0]   busy
);
  localparam int STAGES = WB_DELAY - 1;
  localparam logic [3:0] OP_NOP = 4'b0000;

  logic [3:0] op;
  logic [2:0] mode, rd, rs1, rs2;
  logic       imm_f;
  logic [7:0] imm;
  logic       unused_rsvd;

  assign op          = instr[31:28];
  assign mode        = instr[27:25];
  assign imm_f       = instr[24];
  assign rd          = instr[23:21];
  assign rs1         = instr[20:18];
  assign rs2         = instr[17:15];
  assign imm         = instr[7:0];
  assign unused_rsvd = ^instr[14:8];

  logic [NREGS-1:0][255:0] rf;
  logic [NREGS-1:0]        busy_q;
  logic                    hazard, issue, issue_rd, ld_fire;

  // rs2 is not a real source when the immediate replaces it.
  always_comb begin
    hazard = 1'b0;
    if (op != OP_NOP)
      hazard = busy_q[rs1] | busy_q[rd] | (busy_q[rs2] & ~imm_f);
  end

  assign instr_ready = ~rst & ~hazard;
  assign issue       = instr_valid & instr_ready;
  assign issue_rd    = issue & (op != OP_NOP);
  assign ld_ready    = ~rst & ~busy_q[ld_addr];
  assign ld_fire     = ld_valid & ld_ready;

  // Pending writebacks: stage k holds the entry issued k edges ago.
  logic [STAGES:0]       vld_pipe;
  logic [STAGES:0][2:0]  rd_pipe;
  logic                  wb_en;
  logic [2:0]            wb_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      rd_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], issue_rd};
      rd_pipe  <= {rd_pipe[STAGES-1:0], rd};
    end
  end

  assign wb_en = vld_pipe[STAGES];
  assign wb_rd = rd_pipe[STAGES];

  genvar i;
  generate
    for (i = 0; i < NREGS; i++) begin : g_reg
      simd_issue_vreg u_vreg (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wb_en && (wb_rd == 3'(i))),
        .ld_en    (ld_fire && (ld_addr == 3'(i))),
        .set_busy (issue_rd && (rd == 3'(i))),
        .wb_data  (exec_res),
        .ld_data  (ld_data),
        .q        (rf[i]),
        .busy     (busy_q[i])
      );
    end
  endgenerate

  // Operand fields hold between issues; only the opcode falls back to NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      exec_opcode    <= OP_NOP;
      exec_data_mode <= '0;
      exec_imm_flag  <= 1'b0;
      exec_imm       <= '0;
      exec_A         <= '0;
      exec_B         <= '0;
    end else if (issue) begin
      exec_opcode    <= op;
      exec_data_mode <= mode;
      exec_imm_flag  <= imm_f;
      exec_imm       <= imm;
      exec_A         <= rf[rs1];
      exec_B         <= rf[rs2];
    end else begin
      exec_opcode    <= OP_NOP;
    end
  end

  assign dbg_data = rf[dbg_addr];
  assign busy     = busy_q;
endmodule

// File: tb/tb_simd_issue.sv
// Randomized scoreboard bench for simd_issue with a due-time based reference model.
module tb_simd_issue;
  localparam int WB = 3;

  logic         clk = 1'b0;
  logic         rst, instr_valid, exec_imm_flag, ld_valid, ld_ready, instr_ready;
  logic [31:0]  instr;
  logic [3:0]   exec_opcode;
  logic [2:0]   exec_data_mode, ld_addr, dbg_addr;
  logic [7:0]   exec_imm, busy;
  logic [255:0] exec_A, exec_B, exec_res, ld_data, dbg_data;

  simd_issue #(.WB_DELAY(WB), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .exec_opcode(exec_opcode), .exec_data_mode(exec_data_mode), .exec_imm_flag(exec_imm_flag),
    .exec_imm(exec_imm), .exec_A(exec_A), .exec_B(exec_B), .exec_res(exec_res),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op; logic [2:0] mode; logic immf; logic [7:0] imm;
    logic [255:0] a; logic [255:0] b;
  } exp_t;
  typedef struct { logic [2:0] rd; int due; logic [255:0] res; } pend_t;

  exp_t         sbq[$];
  pend_t        pq[$];
  exp_t         hold;
  logic [255:0] rf_m [8];
  int           edge_n = 0, n_cmp = 0, n_err = 0;
  logic         mon_on = 1'b0, mon_stop = 1'b0, dut_rdy;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Reference "executor": lane-wise byte add.
  function automatic logic [255:0] bsum(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = a[8*k +: 8] + b[8*k +: 8];
    return r;
  endfunction

  function automatic logic [7:0] busy_m();
    logic [7:0] m = '0;
    foreach (pq[k]) m[pq[k].rd] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] mode, input logic immf,
                                     input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [7:0] imm);
    logic [6:0] rsv = 7'($urandom);
    return {op, mode, immf, rd, rs1, rs2, rsv, imm};
  endfunction

  function automatic void model_reset();
    foreach (rf_m[k]) rf_m[k] = '0;
    pq.delete();
    sbq.delete();
    hold = '{4'h0, 3'h0, 1'b0, 8'h0, 256'h0, 256'h0};
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic lv, input logic [2:0] la,
                      input logic [255:0] ld, input logic r, output logic issued);
    logic [7:0]   bm;
    logic         hz, rdy_m, ldr_m;
    logic [3:0]   op;
    logic [255:0] res_now, ea, eb;
    int           idx;
    exp_t         e;
    @(negedge clk);
    rst = r; instr_valid = v; instr = ins; ld_valid = lv; ld_addr = la; ld_data = ld;
    dbg_addr = 3'($urandom_range(0, 7));
    res_now = rnd256();
    foreach (pq[k]) if (pq[k].due == edge_n + 1) res_now = pq[k].res;
    exec_res = res_now;
    #1;
    bm = busy_m();
    op = ins[31:28];
    hz = (op != 4'h0) && (bm[ins[20:18]] || bm[ins[23:21]] || (bm[ins[17:15]] && !ins[24]));
    rdy_m = !r && !hz;
    ldr_m = !r && !bm[la];
    dut_rdy = instr_ready;
    chk("instr_ready", 256'(instr_ready), 256'(rdy_m));
    chk("ld_ready", 256'(ld_ready), 256'(ldr_m));
    chk("busy", 256'(busy), 256'(bm));
    chk("dbg_data", dbg_data, rf_m[dbg_addr]);
    issued = v && rdy_m;
    ea = rf_m[ins[20:18]];
    eb = rf_m[ins[17:15]];
    @(posedge clk);
    edge_n++;
    if (r) model_reset();
    else begin
      idx = -1;
      foreach (pq[k]) if (pq[k].due == edge_n) idx = k;
      if (idx >= 0) begin
        rf_m[pq[idx].rd] = res_now;
        pq.delete(idx);
      end
      if (lv && ldr_m) rf_m[la] = ld;
      if (issued) begin
        e = '{op, ins[27:25], ins[24], ins[7:0], ea, eb};
        hold = e;
        if (op != 4'h0) begin
          pq.push_back('{ins[23:21], edge_n + WB, bsum(ea, eb)});
          sbq.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    logic iss;
    repeat (n) step(1'b0, 32'h0, 1'b0, 3'd0, 256'h0, 1'b0, iss);
  endtask

  task automatic peek(input logic [2:0] a, input logic [255:0] exp, input string nm);
    dbg_addr = a;
    #1;
    chk(nm, dbg_data, exp);
  endtask

  // Monitor: pops an expectation whenever the executor sees a real opcode.
  initial begin
    exp_t e;
    wait (mon_on);
    forever begin
      @(negedge clk);
      if (mon_stop) break;
      if (exec_opcode != 4'h0) begin
        if (sbq.size() == 0) chk("spurious_issue", 256'(exec_opcode), 256'h0);
        else begin
          e = sbq.pop_front();
          chk("exec_opcode", 256'(exec_opcode), 256'(e.op));
          chk("exec_mode", 256'(exec_data_mode), 256'(e.mode));
          chk("exec_immf", 256'(exec_imm_flag), 256'(e.immf));
          chk("exec_imm", 256'(exec_imm), 256'(e.imm));
          chk("exec_A", exec_A, e.a);
          chk("exec_B", exec_B, e.b);
        end
      end else begin
        chk("hold_mode", 256'(exec_data_mode), 256'(hold.mode));
        chk("hold_immf", 256'(exec_imm_flag), 256'(hold.immf));
        chk("hold_imm", 256'(exec_imm), 256'(hold.imm));
        chk("hold_A", exec_A, hold.a);
        chk("hold_B", exec_B, hold.b);
      end
    end
  end

  initial begin
    logic iss;
    int   stalls, tries;
    logic [255:0] v05, v03, v08, vaa;
    v05 = {32{8'h05}}; v03 = {32{8'h03}}; v08 = {32{8'h08}}; vaa = {32{8'hAA}};
    rst = 1'b1; instr_valid = 1'b0; instr = '0; ld_valid = 1'b0; ld_addr = '0;
    ld_data = '0; dbg_addr = '0; exec_res = '0;
    model_reset();
    repeat (2) @(posedge clk);
    mon_on = 1'b1;
    step(1'b1, mk(4'h1, 3'd0, 1'b0, 3'd1, 3'd2, 3'd3, 8'h0), 1'b1, 3'd1, v05, 1'b1, iss);
    step(1'b0, 32'h0, 1'b0, 3'd0, 256'h0, 1'b1, iss);

    // Loads then PADD r3 = r1 + r2; PSUB reading r3 must wait for writeback.
    step(1'b0, 32'h0, 1'b1, 3'd1, v05, 1'b0, iss);
    step(1'b0, 32'h0, 1'b1, 3'd2, v03, 1'b0, iss);
    step(1'b1, mk(4'h1, 3'd2, 1'b0, 3'd3, 3'd1, 3'd2, 8'h11), 1'b0, 3'd0, 256'h0, 1'b0, iss);
    chk("padd_issued", 256'(iss), 256'h1);
    stalls = 0; tries = 0; iss = 1'b0;
    while (!iss && tries < 20) begin
      step(1'b1, mk(4'h2, 3'd2, 1'b0, 3'd6, 3'd3, 3'd1, 8'h22), 1'b0, 3'd0, 256'h0, 1'b0, iss);
      if (!dut_rdy) stalls++;
      tries++;
    end
    chk("psub_issue_timeout", 256'(iss), 256'h1);
    chk("raw_stall_cycles", 256'(stalls), 256'd3);
    peek(3'd3, v08, "r3_after_wb");
    idle(4);

    // Immediate form ignores busy rs2; blocked load to r3, parallel load to r4 at r3 writeback.
    step(1'b1, mk(4'h1, 3'd0, 1'b0, 3'd3, 3'd1, 3'd2, 8'h0), 1'b0, 3'd0, 256'h0, 1'b0, iss);
    step(1'b1, mk(4'h3, 3'd1, 1'b1, 3'd7, 3'd1, 3'd3, 8'h04), 1'b1, 3'd3, rnd256(), 1'b0, iss);
    chk("psll_no_stall", 256'(dut_rdy), 256'h1);
    step(1'b1, mk(4'h0, 3'd5, 1'b0, 3'd7, 3'd3, 3'd3, 8'h5A), 1'b0, 3'd0, 256'h0, 1'b0, iss);
    chk("nop_ready", 256'(dut_rdy), 256'h1);
    step(1'b0, 32'h0, 1'b1, 3'd4, vaa, 1'b0, iss);
    peek(3'd4, vaa, "r4_parallel_load");
    peek(3'd3, v08, "r3_wb_with_load");
    idle(4);

    // Reset drops a pending writeback.
    step(1'b1, mk(4'h1, 3'd0, 1'b0, 3'd5, 3'd1, 3'd2, 8'h0), 1'b0, 3'd0, 256'h0, 1'b0, iss);
    step(1'b0, 32'h0, 1'b0, 3'd0, 256'h0, 1'b1, iss);
    idle(4);
    peek(3'd5, 256'h0, "r5_dropped");
    chk("busy_after_rst", 256'(busy), 256'h0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      step($urandom_range(0, 3) != 0,
           mk(op, 3'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom)),
           $urandom_range(0, 3) == 0, 3'($urandom), rnd256(), $urandom_range(0, 299) == 0, iss);
    end
    idle(WB + 2);
    mon_stop = 1'b1;
    @(negedge clk);
    chk("scoreboard_drained", 256'(sbq.size()), 256'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
